// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks one-hot rows, debounces a single-key press
// and its release, and shifts each accepted key into a two-digit display.
module keypad_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES   = 240,
   parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] async_col,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [3:0] s1,
   output logic [3:0] s2
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam logic [23:0] SETTLE_LAST   = 24'(SETTLE_CYCLES - 1);
   localparam logic [23:0] DEBOUNCE_LAST = 24'(DEBOUNCE_CYCLES - 1);

   logic [3:0]  col_meta_reg, col_reg;
   state_t      state_reg, state_next;
   logic [1:0]  r_reg, r_next;
   logic [1:0]  kr_reg, kr_next;
   logic [3:0]  kc_reg, kc_next;
   logic [23:0] cnt_reg, cnt_next;
   logic [3:0]  key_code_reg, key_code_next;
   logic [3:0]  s1_reg, s1_next;
   logic [3:0]  s2_reg, s2_next;
   logic        key_valid_reg, key_valid_next;
   logic        key_held_reg, key_held_next;
   logic        col_single;
   logic [1:0]  kc_idx;
   logic [3:0]  new_code;

   function automatic logic [3:0] map_key(input logic [1:0] rr, input logic [1:0] cc);
      map_key = 4'h0;
      case ({rr, cc})
         4'h0: map_key = 4'hA;
         4'h1: map_key = 4'h0;
         4'h2: map_key = 4'hB;
         4'h3: map_key = 4'hF;
         4'h4: map_key = 4'h7;
         4'h5: map_key = 4'h8;
         4'h6: map_key = 4'h9;
         4'h7: map_key = 4'hE;
         4'h8: map_key = 4'h4;
         4'h9: map_key = 4'h5;
         4'hA: map_key = 4'h6;
         4'hB: map_key = 4'hD;
         4'hC: map_key = 4'h1;
         4'hD: map_key = 4'h2;
         4'hE: map_key = 4'h3;
         4'hF: map_key = 4'hC;
         default: map_key = 4'h0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_meta_reg <= 4'd0;
         col_reg      <= 4'd0;
      end else begin
         col_meta_reg <= async_col;
         col_reg      <= col_meta_reg;
      end
   end

   // Zero or several active columns (ghosting) never count as a press.
   assign col_single = (col_reg != 4'd0) && ((col_reg & (col_reg - 4'd1)) == 4'd0);

   always_comb begin
      kc_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (kc_reg[i]) kc_idx = 2'(i);
      end
   end

   assign new_code = map_key(kr_reg, kc_idx);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         assign row[gi] = (r_reg == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= SCAN;
         r_reg         <= 2'd0;
         kr_reg        <= 2'd0;
         kc_reg        <= 4'd0;
         cnt_reg       <= 24'd0;
         key_code_reg  <= 4'd0;
         s1_reg        <= 4'd0;
         s2_reg        <= 4'd0;
         key_valid_reg <= 1'b0;
         key_held_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         r_reg         <= r_next;
         kr_reg        <= kr_next;
         kc_reg        <= kc_next;
         cnt_reg       <= cnt_next;
         key_code_reg  <= key_code_next;
         s1_reg        <= s1_next;
         s2_reg        <= s2_next;
         key_valid_reg <= key_valid_next;
         key_held_reg  <= key_held_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      r_next         = r_reg;
      kr_next        = kr_reg;
      kc_next        = kc_reg;
      cnt_next       = cnt_reg;
      key_code_next  = key_code_reg;
      s1_next        = s1_reg;
      s2_next        = s2_reg;
      key_valid_next = 1'b0;
      key_held_next  = key_held_reg;
      case (state_reg)
         SCAN: begin
            if (cnt_reg == SETTLE_LAST) begin
               cnt_next = 24'd0;
               if (col_single) begin
                  kr_next    = r_reg;
                  kc_next    = col_reg;
                  state_next = DEBOUNCE;
               end else begin
                  r_next = r_reg + 2'd1;
               end
            end else begin
               cnt_next = cnt_reg + 24'd1;
            end
         end
         DEBOUNCE: begin
            if (col_reg != kc_reg) begin
               state_next = SCAN;
               cnt_next   = 24'd0;
            end else if (cnt_reg == DEBOUNCE_LAST) begin
               state_next     = HELD;
               cnt_next       = 24'd0;
               key_code_next  = new_code;
               s1_next        = s2_reg;
               s2_next        = new_code;
               key_valid_next = 1'b1;
               key_held_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 24'd1;
            end
         end
         HELD: begin
            // Row stays parked on kr; other keys on this row are ignored.
            if ((col_reg & kc_reg) == 4'd0) begin
               state_next = RELEASE;
               cnt_next   = 24'd0;
            end
         end
         RELEASE: begin
            if ((col_reg & kc_reg) != 4'd0) begin
               state_next = HELD;
               cnt_next   = 24'd0;
            end else if (cnt_reg == DEBOUNCE_LAST) begin
               state_next    = SCAN;
               cnt_next      = 24'd0;
               r_next        = kr_reg + 2'd1;
               key_held_next = 1'b0;
            end else begin
               cnt_next = cnt_reg + 24'd1;
            end
         end
         default: begin
            state_next = SCAN;
            cnt_next   = 24'd0;
         end
      endcase
   end

   assign key_code  = key_code_reg;
   assign key_valid = key_valid_reg;
   assign key_held  = key_held_reg;
   assign s1        = s1_reg;
   assign s2        = s2_reg;

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 240: cycles a row is driven before columns are sampled (10 us at 24 MHz); legal range 1..2^24-1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 480000: consecutive stable cycles required to accept a press or a release (20 ms at 24 MHz); legal range 1..2^24-1.
REQ-003 clk  input  1  single system clock (24 MHz); all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (0) forces reset state immediately, and release is sampled on clk.
REQ-005 async_col  input  4  raw keypad column lines, active-high, asynchronous to clk.
REQ-006 row  output  4  one-hot, active-high row drive.
REQ-007 key_code  output  4  hex value of the most recently accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a key press is accepted.
REQ-009 key_held  output  1  high while an accepted key is still considered pressed.
REQ-010 s1  output  4  older displayed digit.
REQ-011 s2  output  4  newest displayed digit.

Function
REQ-012 async_col SHALL pass through an internal 2-flop synchronizer (reset value 0) to produce col, and all decisions SHALL use col only.
REQ-013 The FSM SHALL have exactly these states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 The block SHALL use a 2-bit row index r with row = 1<<r, and r SHALL change only on SCAN-to-SCAN advance or on RELEASE-to-SCAN exit.
REQ-015 SCAN behaviour:
- The counter SHALL increment each cycle.
- At count SETTLE_CYCLES-1, col SHALL be sampled.
- If col has exactly one bit set, the block SHALL capture (r, col) into (kr, kc), clear the counter and go to DEBOUNCE.
- Otherwise, r SHALL advance as r+1 mod 4 (3 wraps to 0) and the counter SHALL clear.
REQ-016 A col value with zero bits set, or with two or more bits set (ghosting/multi-key), SHALL be treated as no press.
REQ-017 DEBOUNCE behaviour:
- If col == kc, the counter SHALL increment.
- If col != kc, the block SHALL return to SCAN with the same r and the counter cleared.
- On the cycle with counter == DEBOUNCE_CYCLES-1 and col == kc, the press SHALL be accepted.
REQ-018 On acceptance, the following SHALL all be registered in the same edge:
- state goes to HELD;
- key_code gets the code mapped from (kr, kc);
- s1 gets s2 and s2 gets the new code;
- key_valid is 1 for exactly that one following cycle;
- key_held becomes 1.
REQ-019 Key map, listed as row r: col bit0, bit1, bit2, bit3:
- r0: A, 0, B, F
- r1: 7, 8, 9, E
- r2: 4, 5, 6, D
- r3: 1, 2, 3, C
REQ-020 HELD behaviour:
- row SHALL stay at kr.
- When col & kc == 0, the block SHALL go to RELEASE with the counter cleared.
- Additional keys pressed in HELD SHALL be ignored (no rollover, no new key_valid).
REQ-021 RELEASE behaviour:
- If col & kc == 0, the counter SHALL increment.
- If the kc bit reasserts, the block SHALL return to HELD with the counter cleared.
- At counter == DEBOUNCE_CYCLES-1 with the bit still low, the block SHALL go to SCAN with r = kr+1 mod 4, key_held = 0 and the counter cleared.
REQ-022 The counter SHALL be 24 bits wide, SHALL never wrap, and SHALL be cleared on every state transition.
REQ-023 key_valid SHALL never be high for two consecutive cycles, and at most one key_valid SHALL occur per press/release cycle.
REQ-024 s1, s2 and key_code SHALL change only on acceptance and SHALL otherwise hold their values indefinitely.
REQ-025 Latency from a clean press, given col stable and the scan on the key's row, SHALL be:
- 2 cycles for the synchronizer;
- plus the remaining settle cycles;
- plus DEBOUNCE_CYCLES;
- plus 1 cycle to key_valid.

Reset
REQ-026 While reset is 0, the block SHALL hold:
- state = SCAN, r = 0, row = 4'b0001, counter = 0;
- key_code = 0, key_valid = 0, key_held = 0;
- s1 = 0, s2 = 0;
- kr = 0, kc = 0, synchronizer flops = 0.
REQ-027 A reset asserted mid-DEBOUNCE, mid-HELD or mid-RELEASE SHALL abort without emitting key_valid, and scanning SHALL restart at row 0 on the first clk edge after release.

Verification (SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-028 The bench SHALL cover the following directed scenarios:
- Idle: async_col = 0 for 64 cycles -> row rotates 0001, 0010, 0100, 1000, 0001 every 4 cycles; key_valid stays 0.
- Press '5': async_col = 0010 held while row = 0100 -> exactly one key_valid; key_code = 5; s2 = 5; s1 = previous s2; key_held = 1; row frozen at 0100 until release.
- Bounce: async_col toggles 0001/0000 every 3 cycles on row 0001 -> no key_valid, and the FSM keeps returning to SCAN; a subsequent stable press of 'A' yields key_code = A.
- Multi-key: async_col = 0011 on row 1000 -> treated as no press, no key_valid, and the scan continues to 0001.
- Release and sequence: press '1', release, press 'C' -> s1 = 1, s2 = C; a release glitch shorter than 8 cycles in RELEASE -> back to HELD, no second key_valid.
- Reset mid-HELD: drive reset = 0 for 1 cycle -> all outputs return to their reset values immediately, and row = 0001 after release.
